// File: rtl/data_memory.sv
// Word-organised data RAM for the load/store stage: synchronous writes, combinational gated reads.
// The whole array clears asynchronously on rst, so it maps to registers rather than block RAM.
module data_memory #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  writeEnable,
    input  logic                  readEnable,
    output logic [DATA_WIDTH-1:0] readData
);

    localparam int INDEX_WIDTH = $clog2(DEPTH_WORDS);
    localparam int INDEX_LSB   = 2;
    localparam int INDEX_MSB   = INDEX_WIDTH + INDEX_LSB - 1;

    logic [INDEX_WIDTH-1:0] wordIndex;
    logic                   inRange;
    logic                   writeHit;
    logic [DEPTH_WORDS-1:0] wordWriteEn;
    logic [DATA_WIDTH-1:0]  memReg [DEPTH_WORDS];

    // Byte-offset bits select nothing: every access covers the enclosing word.
    logic unusedAlignBits;
    assign unusedAlignBits = ^address[INDEX_LSB-1:0];

    assign wordIndex = address[INDEX_MSB:INDEX_LSB];

    generate
        if (ADDR_WIDTH > INDEX_MSB + 1) begin : gen_range_check
            assign inRange = (address[ADDR_WIDTH-1:INDEX_MSB+1] == '0);
        end else begin : gen_no_range_check
            assign inRange = 1'b1;
        end
    endgenerate

    assign writeHit = writeEnable && inRange;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH_WORDS; gi++) begin : gen_word
            assign wordWriteEn[gi] = writeHit && (wordIndex == INDEX_WIDTH'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    memReg[gi] <= '0;
                end else if (wordWriteEn[gi]) begin
                    memReg[gi] <= writeData;
                end
            end
        end
    endgenerate

    always_comb begin
        readData = '0;
        if (readEnable && inRange) begin
            readData = memReg[wordIndex];
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios followed by random traffic
// compared against a word-array reference model.
module tb_data_memory;

    logic        clk;
    logic        rst;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        writeEnable;
    logic        readEnable;
    logic [31:0] readData;

    int assertCount;
    int failCount;

    logic [31:0] modelMem [256];

    data_memory dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .writeData   (writeData),
        .writeEnable (writeEnable),
        .readEnable  (readEnable),
        .readData    (readData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] modelRead(input logic [31:0] addr, input logic en);
        if (!en || addr >= 32'd1024) return 32'h0;
        return modelMem[addr / 4];
    endfunction

    task automatic modelClear();
        for (int i = 0; i < 256; i++) modelMem[i] = 32'h0;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] expected);
        assertCount++;
        assert (readData === expected)
        else begin
            failCount++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, readData, expected);
        end
    endtask

    task automatic checkRead(input string tag, input logic [31:0] addr, input logic en);
        address    = addr;
        readEnable = en;
        writeEnable = 1'b0;
        #1;
        checkValue(tag, modelRead(addr, en));
        $display("read  addr=%08h en=%0b data=%08h", addr, en, readData);
    endtask

    task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input logic ren);
        @(negedge clk);
        address     = addr;
        writeData   = data;
        writeEnable = 1'b1;
        readEnable  = ren;
        @(posedge clk);
        if (!rst && addr < 32'd1024) modelMem[addr / 4] = data;
        #1;
        writeEnable = 1'b0;
        $display("write addr=%08h data=%08h rst=%0b", addr, data, rst);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst         = 1'b1;
        address     = '0;
        writeData   = '0;
        writeEnable = 1'b0;
        readEnable  = 1'b0;
        modelClear();

        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        checkRead("reset_read_w0", 32'h0, 1'b1);
        checkRead("reset_read_w255", 32'h3FC, 1'b1);

        doWrite(32'h0, 32'h12345678, 1'b0);
        checkValue("rden0_zero", 32'h0);
        checkRead("readback_w0", 32'h0, 1'b1);

        doWrite(32'h4, 32'hCAFEBABE, 1'b0);
        checkRead("align_5", 32'h5, 1'b1);
        checkRead("align_6", 32'h6, 1'b1);
        checkRead("align_7", 32'h7, 1'b1);
        checkRead("align_8", 32'h8, 1'b1);
        checkValue("align_8_const", 32'h0);

        doWrite(32'h400, 32'hDEADBEEF, 1'b1);
        checkRead("oor_read_400", 32'h400, 1'b1);
        checkValue("oor_read_const", 32'h0);
        checkRead("oor_w0_intact", 32'h0, 1'b1);
        checkValue("oor_w0_const", 32'h12345678);

        // Last-word boundary and back-to-back writes to the same word.
        doWrite(32'h3FC, 32'hA5A5A5A5, 1'b0);
        doWrite(32'h3FC, 32'h5A5A5A5A, 1'b0);
        checkRead("last_word_b2b", 32'h3FE, 1'b1);

        // Read-during-write on word 3.
        doWrite(32'hC, 32'h11111111, 1'b0);
        @(negedge clk);
        address     = 32'hC;
        writeData   = 32'h22222222;
        writeEnable = 1'b1;
        readEnable  = 1'b1;
        #1;
        checkValue("rdw_before_edge", 32'h11111111);
        @(posedge clk);
        modelMem[3] = 32'h22222222;
        #1;
        writeEnable = 1'b0;
        checkValue("rdw_after_edge", 32'h22222222);

        // Asynchronous reset between edges.
        @(negedge clk);
        address    = 32'h0;
        readEnable = 1'b1;
        #1;
        checkValue("pre_async_rst", 32'h12345678);
        rst = 1'b1;
        modelClear();
        #1;
        checkValue("async_rst_clear", 32'h0);
        doWrite(32'h0, 32'h87654321, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        checkRead("write_during_rst", 32'h0, 1'b1);
        checkRead("rst_cleared_w3", 32'hC, 1'b1);

        doWrite(32'h8, 32'h0BADF00D, 1'b0);
        checkRead("post_rst_write", 32'h8, 1'b1);

        // Random traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] addr;
            logic [31:0] data;
            if ($urandom_range(0, 7) == 0) addr = $urandom;
            else addr = 32'($urandom_range(0, 1023));
            data = $urandom;
            if ($urandom_range(0, 1) == 1) doWrite(addr, data, 1'($urandom_range(0, 1)));
            else checkRead("random_read", addr, 1'($urandom_range(0, 3) != 0));
        end

        for (int i = 0; i < 256; i += 17) begin
            checkRead("sweep_read", 32'(i * 4 + (i % 4)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
